// File: rtl/sdram_arbiter.sv
// Arbitrates the single SDRAM Avalon-MM master between the VGA prefetcher and the draw engine.
// Holds one registered command and routes read data back through an in-order tag FIFO.
module sdram_arbiter #(
    parameter int AW           = 26,
    parameter int DW           = 32,
    parameter int MAX_OUTST    = 8,
    parameter int STARVE_LIMIT = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [AW-1:0] vga_address,
    input  logic          vga_read,
    output logic          vga_waitrequest,
    output logic [DW-1:0] vga_readdata,
    output logic          vga_readdatavalid,
    input  logic [AW-1:0] draw_address,
    input  logic          draw_read,
    input  logic          draw_write,
    input  logic [DW-1:0] draw_writedata,
    input  logic [3:0]    draw_byteenable,
    output logic          draw_waitrequest,
    output logic [DW-1:0] draw_readdata,
    output logic          draw_readdatavalid,
    output logic [AW-1:0] master_address,
    output logic          master_read,
    output logic          master_write,
    output logic [DW-1:0] master_writedata,
    output logic [3:0]    master_byteenable,
    input  logic          master_waitrequest,
    input  logic [DW-1:0] master_readdata,
    input  logic          master_readdatavalid,
    output logic          err_unexpected_rdv
);
    localparam int PW = $clog2(MAX_OUTST);
    localparam int CW = PW + 1;
    localparam int SW = $clog2(STARVE_LIMIT + 1);

    logic                 cmd_read_q, cmd_write_q;
    logic [AW-1:0]        addr_q;
    logic [DW-1:0]        wdata_q;
    logic [3:0]           be_q;
    logic [MAX_OUTST-1:0] tag_q;
    logic [PW-1:0]        wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]        count_q, count_d;
    logic [SW-1:0]        starve_q, starve_d;
    logic                 vga_rdv_q, draw_rdv_q, err_q;
    logic [DW-1:0]        vga_rdata_q, draw_rdata_q;

    logic cmd_valid, accept, load_ok, rd_ok;
    logic vga_elig, draw_elig, draw_req;
    logic grant_vga, grant_draw, push, pop;

    always_comb begin
        cmd_valid  = cmd_read_q | cmd_write_q;
        accept     = cmd_valid & ~master_waitrequest;
        load_ok    = (~cmd_valid | accept) & ~reset;
        // count_q already includes a read sitting in the command register
        rd_ok      = count_q < CW'(MAX_OUTST);
        vga_elig   = vga_read & rd_ok;
        draw_elig  = draw_write | (draw_read & rd_ok);
        draw_req   = draw_read | draw_write;
        grant_vga  = 1'b0;
        grant_draw = 1'b0;
        if (load_ok) begin
            if (vga_elig && draw_elig) begin
                if (starve_q == SW'(STARVE_LIMIT)) grant_draw = 1'b1;
                else                               grant_vga  = 1'b1;
            end else begin
                grant_vga  = vga_elig;
                grant_draw = draw_elig;
            end
        end
        push    = grant_vga | (grant_draw & ~draw_write);
        pop     = master_readdatavalid & (count_q != '0);
        count_d = count_q + CW'(push) - CW'(pop);

        starve_d = starve_q;
        if (grant_draw || !draw_req)                          starve_d = '0;
        else if (grant_vga && starve_q != SW'(STARVE_LIMIT)) starve_d = starve_q + SW'(1);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cmd_read_q   <= 1'b0;
            cmd_write_q  <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            be_q         <= '0;
            tag_q        <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            starve_q     <= '0;
            vga_rdv_q    <= 1'b0;
            draw_rdv_q   <= 1'b0;
            vga_rdata_q  <= '0;
            draw_rdata_q <= '0;
            err_q        <= 1'b0;
        end else begin
            if (load_ok) begin
                cmd_read_q  <= push;
                cmd_write_q <= grant_draw & draw_write;
                if (grant_vga) begin
                    addr_q  <= vga_address;
                    wdata_q <= '0;
                    be_q    <= 4'hF;
                end else if (grant_draw) begin
                    addr_q  <= draw_address;
                    wdata_q <= draw_write ? draw_writedata : '0;
                    be_q    <= draw_write ? draw_byteenable : 4'hF;
                end
            end
            if (push) begin
                tag_q[wr_ptr_q] <= grant_draw;
                wr_ptr_q        <= wr_ptr_q + PW'(1);
            end
            if (pop) rd_ptr_q <= rd_ptr_q + PW'(1);
            count_q    <= count_d;
            starve_q   <= starve_d;
            vga_rdv_q  <= pop & ~tag_q[rd_ptr_q];
            draw_rdv_q <= pop & tag_q[rd_ptr_q];
            if (pop && !tag_q[rd_ptr_q]) vga_rdata_q  <= master_readdata;
            if (pop && tag_q[rd_ptr_q])  draw_rdata_q <= master_readdata;
            if (master_readdatavalid && count_q == '0) err_q <= 1'b1;
        end
    end

    assign vga_waitrequest    = ~grant_vga;
    assign draw_waitrequest   = ~grant_draw;
    assign vga_readdata       = vga_rdata_q;
    assign vga_readdatavalid  = vga_rdv_q;
    assign draw_readdata      = draw_rdata_q;
    assign draw_readdatavalid = draw_rdv_q;
    assign master_address     = addr_q;
    assign master_read        = cmd_read_q;
    assign master_write       = cmd_write_q;
    assign master_writedata   = wdata_q;
    assign master_byteenable  = be_q;
    assign err_unexpected_rdv = err_q;
endmodule

// File: tb/tb_sdram_arbiter.sv
// Bench for sdram_arbiter: SDRAM responder model plus an in-order scoreboard of expected read beats.
module tb_sdram_arbiter;
    localparam int AW  = 26;
    localparam int DW  = 32;
    localparam int LAT = 3;

    logic          clk = 1'b0;
    logic          reset;
    logic [AW-1:0] vga_address;
    logic          vga_read, vga_waitrequest, vga_readdatavalid;
    logic [DW-1:0] vga_readdata;
    logic [AW-1:0] draw_address;
    logic          draw_read, draw_write, draw_waitrequest, draw_readdatavalid;
    logic [DW-1:0] draw_writedata, draw_readdata;
    logic [3:0]    draw_byteenable;
    logic [AW-1:0] master_address;
    logic          master_read, master_write, master_waitrequest, master_readdatavalid;
    logic [DW-1:0] master_writedata, master_readdata;
    logic [3:0]    master_byteenable;
    logic          err_unexpected_rdv;

    always #5 clk = ~clk;

    sdram_arbiter dut (
        .clk(clk), .reset(reset),
        .vga_address(vga_address), .vga_read(vga_read), .vga_waitrequest(vga_waitrequest),
        .vga_readdata(vga_readdata), .vga_readdatavalid(vga_readdatavalid),
        .draw_address(draw_address), .draw_read(draw_read), .draw_write(draw_write),
        .draw_writedata(draw_writedata), .draw_byteenable(draw_byteenable),
        .draw_waitrequest(draw_waitrequest), .draw_readdata(draw_readdata),
        .draw_readdatavalid(draw_readdatavalid),
        .master_address(master_address), .master_read(master_read), .master_write(master_write),
        .master_writedata(master_writedata), .master_byteenable(master_byteenable),
        .master_waitrequest(master_waitrequest), .master_readdata(master_readdata),
        .master_readdatavalid(master_readdatavalid), .err_unexpected_rdv(err_unexpected_rdv)
    );

    typedef struct { logic port; logic [DW-1:0] data; } exp_t;
    typedef struct { logic [AW-1:0] addr; int due; } pend_t;
    exp_t  sb[$];
    pend_t pend[$];

    int n_checks = 0, n_fail = 0, cyc = 0;
    int n_vrdv = 0, n_drdv = 0, rdv_credit = 0;
    bit rdv_en = 1'b0, g_vga, g_draw;

    function automatic logic [DW-1:0] mem_f(input logic [AW-1:0] a);
        return 32'hC0DE_0000 ^ {6'b0, a};
    endfunction

    // One clock: sample grants/beats at negedge, then drive SDRAM return data just after posedge.
    task automatic tick();
        exp_t  e;
        pend_t p;
        @(negedge clk);
        g_vga  = vga_read & ~vga_waitrequest;
        g_draw = (draw_read | draw_write) & ~draw_waitrequest;
        if (g_vga) begin
            e.port = 1'b0; e.data = mem_f(vga_address); sb.push_back(e);
        end
        if (g_draw && draw_read && !draw_write) begin
            e.port = 1'b1; e.data = mem_f(draw_address); sb.push_back(e);
        end
        if (master_read && !master_waitrequest) begin
            p.addr = master_address; p.due = cyc + LAT; pend.push_back(p);
        end
        n_checks++;
        if (g_vga && g_draw) begin
            n_fail++; $display("FAIL grant_exclusive: both ports granted at cycle %0d", cyc);
        end
        if (vga_readdatavalid) begin
            n_vrdv++; n_checks++;
            if (sb.size() == 0) begin
                n_fail++; $display("FAIL vga_rdv_unexpected: got data %h, no read outstanding", vga_readdata);
            end else begin
                e = sb.pop_front();
                if (e.port !== 1'b0 || vga_readdata !== e.data) begin
                    n_fail++;
                    $display("FAIL vga_rdv_data: got port 0 data %h, expected port %0d data %h", vga_readdata, e.port, e.data);
                end
            end
        end
        if (draw_readdatavalid) begin
            n_drdv++; n_checks++;
            if (sb.size() == 0) begin
                n_fail++; $display("FAIL draw_rdv_unexpected: got data %h, no read outstanding", draw_readdata);
            end else begin
                e = sb.pop_front();
                if (e.port !== 1'b1 || draw_readdata !== e.data) begin
                    n_fail++;
                    $display("FAIL draw_rdv_data: got port 1 data %h, expected port %0d data %h", draw_readdata, e.port, e.data);
                end
            end
        end
        @(posedge clk);
        cyc++;
        #1;
        master_readdatavalid = 1'b0;
        master_readdata      = '0;
        if (pend.size() > 0 && pend[0].due <= cyc && (rdv_en || rdv_credit > 0)) begin
            p = pend.pop_front();
            master_readdatavalid = 1'b1;
            master_readdata      = mem_f(p.addr);
            if (!rdv_en) rdv_credit--;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) tick();
        n_checks++;
        if (master_read !== 1'b0 || master_write !== 1'b0 || master_address !== '0 ||
            master_writedata !== '0 || master_byteenable !== 4'h0) begin
            n_fail++;
            $display("FAIL reset_master: got rd=%b wr=%b addr=%h wd=%h be=%h, expected all 0",
                     master_read, master_write, master_address, master_writedata, master_byteenable);
        end
        n_checks++;
        if (vga_readdatavalid !== 1'b0 || draw_readdatavalid !== 1'b0 || vga_readdata !== '0 ||
            draw_readdata !== '0 || err_unexpected_rdv !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_resp: got vrdv=%b drdv=%b vd=%h dd=%h err=%b, expected all 0",
                     vga_readdatavalid, draw_readdatavalid, vga_readdata, draw_readdata, err_unexpected_rdv);
        end
        reset = 1'b0;
        #1;
        n_checks++;
        if (vga_waitrequest !== 1'b1 || draw_waitrequest !== 1'b1) begin
            n_fail++;
            $display("FAIL idle_waitreq: got vga=%b draw=%b, expected 1 1", vga_waitrequest, draw_waitrequest);
        end
    endtask

    task automatic test_vga_burst();
        logic [AW-1:0] a [3];
        a[0] = 26'h100; a[1] = 26'h108; a[2] = 26'h110;
        rdv_en = 1'b1; n_vrdv = 0; n_drdv = 0;
        for (int i = 0; i < 3; i++) begin
            vga_address = a[i]; vga_read = 1'b1;
            tick();
            n_checks++;
            if (!g_vga || master_read !== 1'b1 || master_address !== a[i]) begin
                n_fail++;
                $display("FAIL burst_issue%0d: got grant=%b rd=%b addr=%h, expected 1 1 %h",
                         i, g_vga, master_read, master_address, a[i]);
            end
        end
        vga_read = 1'b0;
        repeat (8) tick();
        n_checks++;
        if (n_vrdv != 3 || n_drdv != 0 || sb.size() != 0) begin
            n_fail++;
            $display("FAIL burst_count: got vga=%0d draw=%0d left=%0d, expected 3 0 0", n_vrdv, n_drdv, sb.size());
        end
    endtask

    task automatic test_starve();
        int sv = 0, iv = 0, id = 0;
        bit exp_d;
        rdv_en = 1'b1;
        vga_read = 1'b1; draw_read = 1'b1;
        for (int c = 0; c < 20; c++) begin
            vga_address  = 26'h1000 + 26'(4 * iv);
            draw_address = 26'h8000 + 26'(4 * id);
            tick();
            if (sv == 4) begin exp_d = 1'b1; sv = 0; end
            else begin exp_d = 1'b0; sv++; end
            n_checks++;
            if (g_draw !== exp_d || g_vga !== !exp_d) begin
                n_fail++;
                $display("FAIL starve_pattern%0d: got vga=%b draw=%b, expected vga=%b draw=%b",
                         c, g_vga, g_draw, !exp_d, exp_d);
            end
            if (g_vga) iv++;
            if (g_draw) id++;
        end
        vga_read = 1'b0; draw_read = 1'b0;
        repeat (10) tick();
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++; $display("FAIL starve_drain: got %0d beats missing, expected 0", sb.size());
        end
    endtask

    task automatic test_waitreq_hold();
        draw_address = 26'h2000; draw_writedata = 32'hDEADBEEF; draw_byteenable = 4'h3;
        draw_write = 1'b1; master_waitrequest = 1'b1;
        tick();
        n_checks++;
        if (!g_draw) begin
            n_fail++; $display("FAIL hold_grant: got draw grant %b, expected 1", g_draw);
        end
        vga_read = 1'b1; vga_address = 26'h140;
        for (int i = 0; i < 5; i++) begin
            #1;
            n_checks++;
            if (master_write !== 1'b1 || master_read !== 1'b0 || master_address !== 26'h2000 ||
                master_writedata !== 32'hDEADBEEF || master_byteenable !== 4'h3 ||
                vga_waitrequest !== 1'b1 || draw_waitrequest !== 1'b1) begin
                n_fail++;
                $display("FAIL hold_cycle%0d: got wr=%b rd=%b addr=%h wd=%h be=%h vwait=%b dwait=%b, expected 1 0 2000 deadbeef 3 1 1",
                         i, master_write, master_read, master_address, master_writedata,
                         master_byteenable, vga_waitrequest, draw_waitrequest);
            end
            tick();
        end
        vga_read = 1'b0; draw_write = 1'b0; master_waitrequest = 1'b0;
        tick();
        n_checks++;
        if (master_write !== 1'b0) begin
            n_fail++; $display("FAIL hold_release: got master_write %b, expected 0", master_write);
        end
    endtask

    task automatic test_outstanding();
        rdv_en = 1'b0; rdv_credit = 0;
        vga_read = 1'b1;
        for (int i = 0; i < 8; i++) begin
            vga_address = 26'h4000 + 26'(4 * i);
            tick();
            n_checks++;
            if (!g_vga) begin
                n_fail++; $display("FAIL outst_issue%0d: got grant %b, expected 1", i, g_vga);
            end
        end
        vga_address = 26'h4020;
        draw_write = 1'b1; draw_address = 26'h5000; draw_writedata = 32'h0BAD_F00D; draw_byteenable = 4'hF;
        tick();
        n_checks++;
        if (g_vga !== 1'b0 || g_draw !== 1'b1) begin
            n_fail++; $display("FAIL outst_full: got vga=%b draw=%b, expected 0 1", g_vga, g_draw);
        end
        draw_write = 1'b0;
        tick();
        rdv_credit = 1;
        tick();
        tick();
        n_checks++;
        if (g_vga !== 1'b0) begin
            n_fail++; $display("FAIL outst_beat_cycle: got vga grant %b, expected 0", g_vga);
        end
        tick();
        n_checks++;
        if (g_vga !== 1'b1) begin
            n_fail++; $display("FAIL outst_after_pop: got vga grant %b, expected 1", g_vga);
        end
        vga_read = 1'b0; rdv_en = 1'b1;
        repeat (16) tick();
        n_checks++;
        if (sb.size() != 0 || pend.size() != 0) begin
            n_fail++; $display("FAIL outst_drain: got %0d/%0d left, expected 0/0", sb.size(), pend.size());
        end
    endtask

    task automatic test_rw_both();
        rdv_en = 1'b1; n_vrdv = 0; n_drdv = 0;
        draw_read = 1'b1; draw_write = 1'b1; draw_address = 26'h3000;
        draw_writedata = 32'h1234_5678; draw_byteenable = 4'hC;
        tick();
        draw_read = 1'b0; draw_write = 1'b0;
        n_checks++;
        if (!g_draw || master_write !== 1'b1 || master_read !== 1'b0 ||
            master_address !== 26'h3000 || master_writedata !== 32'h1234_5678 || master_byteenable !== 4'hC) begin
            n_fail++;
            $display("FAIL rw_both: got grant=%b wr=%b rd=%b addr=%h wd=%h be=%h, expected 1 1 0 3000 12345678 c",
                     g_draw, master_write, master_read, master_address, master_writedata, master_byteenable);
        end
        tick();
        vga_read = 1'b1; vga_address = 26'h180;
        tick();
        vga_read = 1'b0;
        repeat (8) tick();
        n_checks++;
        if (n_vrdv != 1 || n_drdv != 0 || sb.size() != 0) begin
            n_fail++;
            $display("FAIL rw_no_tag: got vga=%0d draw=%0d left=%0d, expected 1 0 0", n_vrdv, n_drdv, sb.size());
        end
    endtask

    task automatic test_reset_midop();
        rdv_en = 1'b0;
        vga_read = 1'b1;
        for (int i = 0; i < 3; i++) begin
            vga_address = 26'h200 + 26'(8 * i);
            tick();
        end
        vga_read = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        sb.delete();
        n_vrdv = 0; n_drdv = 0;
        n_checks++;
        if (master_read !== 1'b0 || err_unexpected_rdv !== 1'b0) begin
            n_fail++; $display("FAIL midrst_clear: got rd=%b err=%b, expected 0 0", master_read, err_unexpected_rdv);
        end
        rdv_en = 1'b1;
        tick();
        tick();
        n_checks++;
        if (err_unexpected_rdv !== 1'b1) begin
            n_fail++; $display("FAIL midrst_err: got err %b, expected 1", err_unexpected_rdv);
        end
        repeat (6) tick();
        n_checks++;
        if (n_vrdv != 0 || n_drdv != 0 || err_unexpected_rdv !== 1'b1) begin
            n_fail++;
            $display("FAIL midrst_stray: got vga=%0d draw=%0d err=%b, expected 0 0 1", n_vrdv, n_drdv, err_unexpected_rdv);
        end
    endtask

    initial begin
        reset = 1'b1;
        vga_address = '0; vga_read = 1'b0;
        draw_address = '0; draw_read = 1'b0; draw_write = 1'b0;
        draw_writedata = '0; draw_byteenable = '0;
        master_waitrequest = 1'b0; master_readdata = '0; master_readdatavalid = 1'b0;
        test_reset();
        test_vga_burst();
        test_starve();
        test_waitreq_hold();
        test_outstanding();
        test_rw_both();
        test_reset_midop();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, expected finish", $time);
        $fatal(1);
    end
endmodule
